uart_tx: RTL and testbench

UART transmit channel. It serializes one parallel word per valid/ready handshake onto a single line, in this order: a start bit, BYTESIZES data bits LSB first, an optional parity bit, then 1 or 2 stop bits. Bit timing comes from an internal divider that runs on the system clock, so no external baud generator is needed. It pairs with the UART receive channel at the far end of the serial link.

---
 rtl/uart_tx.sv | 163 ++++++++++++++++
 tb/tb_uart_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmit channel: start bit, BYTESIZES data bits LSB first, optional parity,
// 1 or 2 stop bits. Bit timing comes from an internal clock divider.
module uart_tx #(
  parameter int BYTESIZES   = 8,
  parameter int BAUDRATE    = 115200,
  parameter int CLOCK_INPUT = 50_000_000,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOPBITS    = 1
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 valid_tx_in,
  input  logic [BYTESIZES-1:0] data_tx_in,
  output logic                 ready_tx_out,
  output logic                 sdata_tx_out,
  output logic                 busy_tx_out,
  output logic                 done_tx_out
);

  localparam int CLKS_PER_BIT = CLOCK_INPUT / BAUDRATE;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = $clog2(BYTESIZES + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(BYTESIZES - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOPBITS - 1);
  localparam logic              PAR_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [BAUD_W-1:0]     baud_r, baud_s;
  logic [BIT_W-1:0]      bit_r, bit_s;
  logic [BYTESIZES-1:0]  shift_r, shift_s;
  logic                  par_r, par_s;
  logic                  line_r, line_s;
  logic                  done_r, done_s;
  logic                  bit_end_s;

  function automatic logic parity_of(input logic [BYTESIZES-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

  assign bit_end_s    = (baud_r == BAUD_LAST);
  assign ready_tx_out = (state_r == IDLE);
  assign busy_tx_out  = (state_r != IDLE);
  assign sdata_tx_out = line_r;
  assign done_tx_out  = done_r;

  // State register and all datapath flops; outputs are registered from next-state values.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_r <= IDLE;
      baud_r  <= {BAUD_W{1'b0}};
      bit_r   <= {BIT_W{1'b0}};
      shift_r <= {BYTESIZES{1'b0}};
      par_r   <= 1'b0;
      line_r  <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      par_r   <= par_s;
      line_r  <= line_s;
      done_r  <= done_s;
    end
  end

  // Next-state, counter and shift logic.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    par_s   = par_r;
    case (state_r)
      IDLE: begin
        baud_s = {BAUD_W{1'b0}};
        bit_s  = {BIT_W{1'b0}};
        if (valid_tx_in) begin
          state_s = START;
          shift_s = data_tx_in;
          par_s   = parity_of(data_tx_in, PAR_ODD);
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          baud_s  = {BAUD_W{1'b0}};
        end else begin
          baud_s  = baud_r + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_s  = {BAUD_W{1'b0}};
          shift_s = shift_r >> 1;
          if (bit_r == DATA_LAST) begin
            bit_s   = {BIT_W{1'b0}};
            state_s = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_s   = bit_r + {{(BIT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          baud_s = baud_r + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
          baud_s  = {BAUD_W{1'b0}};
          bit_s   = {BIT_W{1'b0}};
        end else begin
          baud_s  = baud_r + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      STOP: begin
        if (bit_end_s) begin
          baud_s = {BAUD_W{1'b0}};
          if (bit_r == STOP_LAST) begin
            state_s = IDLE;
            bit_s   = {BIT_W{1'b0}};
          end else begin
            bit_s   = bit_r + {{(BIT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          baud_s = baud_r + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = {BAUD_W{1'b0}};
        bit_s   = {BIT_W{1'b0}};
      end
    endcase
  end

  // Line level and done pulse for the cycle after the coming edge.
  always_comb begin
    line_s = 1'b1;
    case (state_s)
      IDLE:    line_s = 1'b1;
      START:   line_s = 1'b0;
      DATA:    line_s = shift_s[0];
      PARITY:  line_s = par_s;
      STOP:    line_s = 1'b1;
      default: line_s = 1'b1;
    endcase
    done_s = (state_s == STOP) && (baud_s == BAUD_LAST) && (bit_s == STOP_LAST);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) at 10 clocks/bit,
// per-cycle expectations queued when a word is driven and popped on each falling edge.
module tb_uart_tx;

  localparam int CPB = 1_000_000 / 100_000;

  typedef struct {
    int         cyc;
    logic       line;
    logic       done;
    logic       ready;
  } exp_t;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [11:0] bits;   // frame bits in line order, start bit in bit 0
    int          nbits;
  } vec_t;

  logic       clk;
  logic       nrst [4];
  logic       vin  [4];
  logic [7:0] din  [4];
  logic       rdy  [4];
  logic       sd   [4];
  logic       bsy  [4];
  logic       dn   [4];

  exp_t q[$];
  int   sel;
  int   n_vec;
  int   n_miss;

  uart_tx #(.BYTESIZES(8), .BAUDRATE(100_000), .CLOCK_INPUT(1_000_000),
            .PARITY_EN(0), .PARITY_ODD(0), .STOPBITS(1)) u0 (
    .clock(clk), .nreset(nrst[0]), .valid_tx_in(vin[0]), .data_tx_in(din[0]),
    .ready_tx_out(rdy[0]), .sdata_tx_out(sd[0]), .busy_tx_out(bsy[0]), .done_tx_out(dn[0]));
  uart_tx #(.BYTESIZES(8), .BAUDRATE(100_000), .CLOCK_INPUT(1_000_000),
            .PARITY_EN(1), .PARITY_ODD(0), .STOPBITS(1)) u1 (
    .clock(clk), .nreset(nrst[1]), .valid_tx_in(vin[1]), .data_tx_in(din[1]),
    .ready_tx_out(rdy[1]), .sdata_tx_out(sd[1]), .busy_tx_out(bsy[1]), .done_tx_out(dn[1]));
  uart_tx #(.BYTESIZES(8), .BAUDRATE(100_000), .CLOCK_INPUT(1_000_000),
            .PARITY_EN(1), .PARITY_ODD(1), .STOPBITS(1)) u2 (
    .clock(clk), .nreset(nrst[2]), .valid_tx_in(vin[2]), .data_tx_in(din[2]),
    .ready_tx_out(rdy[2]), .sdata_tx_out(sd[2]), .busy_tx_out(bsy[2]), .done_tx_out(dn[2]));
  uart_tx #(.BYTESIZES(8), .BAUDRATE(100_000), .CLOCK_INPUT(1_000_000),
            .PARITY_EN(0), .PARITY_ODD(0), .STOPBITS(2)) u3 (
    .clock(clk), .nreset(nrst[3]), .valid_tx_in(vin[3]), .data_tx_in(din[3]),
    .ready_tx_out(rdy[3]), .sdata_tx_out(sd[3]), .busy_tx_out(bsy[3]), .done_tx_out(dn[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] obs(input int i);
    return {sd[i], dn[i], rdy[i], bsy[i]};
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s: line/done/ready/busy got %b required %b", name, got, req);
    end
  endtask

  // One clock: wait for the falling edge and compare against the next queued expectation.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("dut%0d cyc%0d", sel, e.cyc), obs(sel), {e.line, e.done, e.ready, ~e.ready});
    end
  endtask

  task automatic push_idle(input int n, input int base);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.cyc = base + k; e.line = 1'b1; e.done = 1'b0; e.ready = 1'b1;
      q.push_back(e);
    end
  endtask

  // Expected line for cycles 1..nbits*CPB after the accept edge, then one idle cycle.
  task automatic push_frame(input logic [11:0] bits, input int nbits, input int base, input int limit);
    exp_t e;
    for (int k = 1; k <= nbits * CPB && k <= limit; k++) begin
      e.cyc   = base + k;
      e.line  = bits[(k - 1) / CPB];
      e.done  = (k == nbits * CPB);
      e.ready = 1'b0;
      q.push_back(e);
    end
    if (limit > nbits * CPB) push_idle(1, base + nbits * CPB);
  endtask

  task automatic drain();
    for (int g = 0; g < 3000 && q.size() > 0; g++) tick();
    if (q.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    sel = v.dut;
    check($sformatf("dut%0d pre-accept", sel), obs(sel), 4'b1010);
    vin[sel] = 1'b1;
    din[sel] = v.data;
    push_frame(v.bits, v.nbits, 0, 100000);
    tick();
    vin[sel] = 1'b0;
    din[sel] = ~v.data;
    drain();
  endtask

  vec_t vt [8];

  initial begin
    n_vec = 0; n_miss = 0; sel = 0;
    vt[0] = '{dut: 0, data: 8'hA5, bits: {2'b00, 1'b1, 8'hA5, 1'b0}, nbits: 10};
    vt[1] = '{dut: 0, data: 8'h00, bits: {2'b00, 1'b1, 8'h00, 1'b0}, nbits: 10};
    vt[2] = '{dut: 0, data: 8'h3C, bits: {2'b00, 1'b1, 8'h3C, 1'b0}, nbits: 10};
    vt[3] = '{dut: 1, data: 8'hA5, bits: {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, nbits: 11};
    vt[4] = '{dut: 2, data: 8'hA5, bits: {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, nbits: 11};
    vt[5] = '{dut: 1, data: 8'h07, bits: {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, nbits: 11};
    vt[6] = '{dut: 3, data: 8'hFF, bits: {1'b0, 2'b11, 8'hFF, 1'b0}, nbits: 11};
    vt[7] = '{dut: 2, data: 8'h00, bits: {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, nbits: 11};

    for (int i = 0; i < 4; i++) begin
      nrst[i] = 1'b0; vin[i] = 1'b0; din[i] = 8'h00;
    end
    tick(); tick();
    for (int i = 0; i < 4; i++) check($sformatf("dut%0d reset", i), obs(i), 4'b1010);
    for (int i = 0; i < 4; i++) nrst[i] = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Back-to-back: valid held high, second start bit at cycle 102.
    sel = 0;
    vin[0] = 1'b1; din[0] = 8'h01;
    push_frame({2'b00, 1'b1, 8'h01, 1'b0}, 10, 0, 100000);
    push_frame({2'b00, 1'b1, 8'h80, 1'b0}, 10, 101, 100000);
    for (int k = 1; k <= 202; k++) begin
      tick();
      if (k == 1) din[0] = 8'h80;
      if (k == 102) vin[0] = 1'b0;
    end
    drain();

    // Valid pulses while busy, including the final stop cycle, are ignored.
    vin[0] = 1'b1; din[0] = 8'h5A;
    push_frame({2'b00, 1'b1, 8'h5A, 1'b0}, 10, 0, 100000);
    push_idle(3, 101);
    for (int k = 1; k <= 101; k++) begin
      tick();
      vin[0] = (k == 20 || k == 50 || k == 99 || k == 100);
      din[0] = 8'h00;
    end
    vin[0] = 1'b0;
    drain();

    // Reset during the frame at cycle 35: line high next cycle, no done pulse.
    vin[0] = 1'b1; din[0] = 8'h00;
    push_frame({2'b00, 1'b1, 8'h00, 1'b0}, 10, 0, 35);
    push_idle(4, 35);
    tick();
    vin[0] = 1'b0;
    for (int k = 2; k <= 35; k++) tick();
    nrst[0] = 1'b0;
    tick();
    nrst[0] = 1'b1;
    drain();
    run_vec(vt[0]);

    // Reset held at idle with valid high: nothing starts until release.
    nrst[0] = 1'b0; vin[0] = 1'b1; din[0] = 8'h33;
    push_idle(3, 0);
    tick(); tick(); tick();
    nrst[0] = 1'b1;
    push_frame({2'b00, 1'b1, 8'h33, 1'b0}, 10, 0, 100000);
    tick();
    vin[0] = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
